// File: rtl/display_source_scheduler.sv
// Round-robin time-slicer feeding one source value at a time to the numeric LED display.
// Optional DISPLAY_SCHED_LOCK_EN adds i_lock, which freezes the dwell count while asserted.
module display_source_scheduler #(
   parameter int NUM_SOURCES   = 4,
   parameter int SRC_IDX_WIDTH = 2,
   parameter int DWELL_CYCLES  = 25_000_000,
   parameter int DWELL_WIDTH   = 25
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
`ifdef DISPLAY_SCHED_LOCK_EN
   input  logic                       i_lock,
`endif
   input  logic [NUM_SOURCES-1:0]     i_req,
   input  logic [16*NUM_SOURCES-1:0]  i_values,
   output logic [NUM_SOURCES-1:0]     o_grant,
   output logic [SRC_IDX_WIDTH-1:0]   o_active_idx,
   output logic [15:0]                o_number_to_display,
   output logic                       o_valid,
   output logic                       o_switch_stb
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SELECT = 2'd1;
   localparam logic [1:0] ST_DWELL  = 2'd2;

   localparam logic [DWELL_WIDTH-1:0]   RELOAD  = DWELL_WIDTH'(DWELL_CYCLES - 1);
   localparam logic [SRC_IDX_WIDTH-1:0] PTR_RST = SRC_IDX_WIDTH'(NUM_SOURCES - 1);

   logic [1:0]               r_state;
   logic [SRC_IDX_WIDTH-1:0] r_ptr;
   logic [DWELL_WIDTH-1:0]   r_cnt;
   logic [NUM_SOURCES-1:0]   r_grant;
   logic [SRC_IDX_WIDTH-1:0] r_idx;
   logic [15:0]              r_num;
   logic                     r_valid;
   logic                     r_stb;

   logic                     w_lock;
   logic                     w_any;
   logic [SRC_IDX_WIDTH-1:0] w_win;
   logic [NUM_SOURCES-1:0]   w_win_oh;
   logic                     w_own_req;
   logic                     w_other;
   logic [15:0]              w_vals [NUM_SOURCES];
   int                       v_c;

`ifdef DISPLAY_SCHED_LOCK_EN
   assign w_lock = i_lock;
`else
   assign w_lock = 1'b0;
`endif

   for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_vals
      assign w_vals[k] = i_values[16*k +: 16];
   end

   // Walk from the farthest candidate inward so the nearest one after r_ptr wins.
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      v_c   = 0;
      for (int k = NUM_SOURCES; k >= 1; k--) begin
         v_c = int'(r_ptr) + k;
         if (v_c >= NUM_SOURCES) v_c = v_c - NUM_SOURCES;
         if (i_req[v_c]) begin
            w_win = SRC_IDX_WIDTH'(v_c);
            w_any = 1'b1;
         end
      end
   end

   assign w_win_oh  = {{(NUM_SOURCES-1){1'b0}}, 1'b1} << w_win;
   assign w_own_req = |(i_req & r_grant);
   assign w_other   = |(i_req & ~r_grant);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= PTR_RST;
         r_cnt   <= '0;
         r_grant <= '0;
         r_idx   <= '0;
         r_num   <= '0;
         r_valid <= 1'b0;
         r_stb   <= 1'b0;
      end else begin
         r_stb <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|i_req) r_state <= ST_SELECT;
            end
            ST_SELECT: begin
               if (w_any) begin
                  r_grant <= w_win_oh;
                  r_idx   <= w_win;
                  r_ptr   <= w_win;
                  r_valid <= 1'b1;
                  r_stb   <= 1'b1;
                  r_num   <= w_vals[w_win];
                  r_cnt   <= RELOAD;
                  r_state <= ST_DWELL;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_DWELL: begin
               if (!w_own_req) begin
                  r_grant <= '0;
                  r_valid <= 1'b0;
                  r_state <= w_other ? ST_SELECT : ST_IDLE;
               end else begin
                  r_num <= w_vals[r_idx];
                  if (!w_lock) begin
                     if (r_cnt == '0) begin
                        if (w_other) begin
                           r_grant <= '0;
                           r_valid <= 1'b0;
                           r_state <= ST_SELECT;
                        end else begin
                           r_cnt <= RELOAD;
                        end
                     end else begin
                        r_cnt <= r_cnt - DWELL_WIDTH'(1);
                     end
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_grant             = r_grant;
   assign o_active_idx        = r_idx;
   assign o_number_to_display = r_num;
   assign o_valid             = r_valid;
   assign o_switch_stb        = r_stb;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Bench for display_source_scheduler: directed scenarios plus randomized traffic
// checked every cycle against a slot-level model of the scheduler.
module tb_display_source_scheduler;

   localparam int N  = 4;
   localparam int DW = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [63:0] vals = '0;
   logic        lock = 1'b0;

   logic [3:0]  o_grant;
   logic [1:0]  o_active_idx;
   logic [15:0] o_number_to_display;
   logic        o_valid;
   logic        o_switch_stb;

   display_source_scheduler #(
      .NUM_SOURCES(N), .SRC_IDX_WIDTH(2),
      .DWELL_CYCLES(DW), .DWELL_WIDTH(4)
   ) dut (
      .i_clk(clk),
      .i_reset_n(rst_n),
`ifdef DISPLAY_SCHED_LOCK_EN
      .i_lock(lock),
`endif
      .i_req(req),
      .i_values(vals),
      .o_grant(o_grant),
      .o_active_idx(o_active_idx),
      .o_number_to_display(o_number_to_display),
      .o_valid(o_valid),
      .o_switch_stb(o_switch_stb)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: owner of the display (-1 none), slot cycles left, pending selection.
   int          m_owner;
   int          m_ptr;
   int          m_left;
   bit          m_sel;
   logic [1:0]  m_idx;
   logic [15:0] m_num;
   bit          m_stb;

   task automatic model_reset();
      m_owner = -1; m_ptr = N - 1; m_left = 0; m_sel = 0;
      m_idx = '0; m_num = '0; m_stb = 0;
   endtask

   function automatic int first_from(int p, logic [3:0] r);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (p + k) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_step();
      int w;
      logic [3:0] own;
      if (!rst_n) begin model_reset(); return; end
      m_stb = 0;
      if (m_sel) begin
         m_sel = 0;
         w = first_from(m_ptr, req);
         if (w >= 0) begin
            m_owner = w; m_ptr = w; m_idx = w[1:0];
            m_left = DW - 1; m_num = vals[16*w +: 16]; m_stb = 1;
         end
      end else if (m_owner >= 0) begin
         own = 4'b0001 << m_owner;
         if ((req & own) == 0) begin
            m_owner = -1;
            m_sel = (req != 0);
         end else begin
            m_num = vals[16*m_owner +: 16];
            if (!lock) begin
               if (m_left == 0) begin
                  if ((req & ~own) != 0) begin
                     m_owner = -1; m_sel = 1;
                  end else begin
                     m_left = DW - 1;
                  end
               end else begin
                  m_left--;
               end
            end
         end
      end else if (req != 0) begin
         m_sel = 1;
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      logic [3:0] eg;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("outputs{grant,idx,num,valid,stb}",
          {8'h0, o_grant, o_active_idx, o_number_to_display, o_valid, o_switch_stb},
          {8'h0, eg, m_idx, m_num, (m_owner >= 0), m_stb});
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   // Asserted between clock edges to exercise the asynchronous path.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      chk("reset_zero",
          {8'h0, o_grant, o_active_idx, o_number_to_display, o_valid, o_switch_stb},
          32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int stb_idx [8];
   int stb_cyc [8];
   int runs [8];
   int n_stb, n_run, run;

   initial begin
      model_reset();
      @(negedge clk);
      @(negedge clk);
      do_reset();

      // Single request: grant two cycles later with one strobe.
      req = 4'b0100;
      vals[47:32] = 16'h1234;
      cyc(); cyc();
      chk("t1_grant", {28'h0, o_grant}, 32'b0100);
      chk("t1_idx", {30'h0, o_active_idx}, 32'd2);
      chk("t1_num", {16'h0, o_number_to_display}, 32'h1234);
      chk("t1_stb", {31'h0, o_switch_stb}, 32'd1);
      cyc();
      chk("t1_stb_clear", {31'h0, o_switch_stb}, 32'd0);

      // Full contention: rotation 0,1,2,3,0 with 8-cycle slots.
      do_reset();
      req = 4'b1111;
      n_stb = 0; n_run = 0; run = 0;
      for (int c = 1; c <= 46; c++) begin
         cyc();
         if (o_switch_stb && n_stb < 8) begin
            stb_idx[n_stb] = int'(o_active_idx);
            stb_cyc[n_stb] = c;
            n_stb++;
         end
         if (o_valid) run++;
         else if (run > 0) begin
            if (n_run < 8) runs[n_run] = run;
            n_run++;
            run = 0;
         end
      end
      chk("t2_nstb", n_stb, 5);
      for (int i = 0; i < 5 && i < n_stb; i++)
         chk("t2_order", stb_idx[i], i % N);
      for (int i = 0; i < 4 && i < n_run; i++)
         chk("t2_slot_len", runs[i], DW);
      for (int i = 0; i < 4 && i + 1 < n_stb; i++)
         chk("t2_spacing", stb_cyc[i+1] - stb_cyc[i], DW + 1);

      // Lone requester keeps the display without re-strobing.
      do_reset();
      req = 4'b0010;
      n_stb = 0;
      for (int c = 0; c < 30; c++) begin
         cyc();
         if (o_switch_stb) n_stb++;
      end
      chk("t3_nstb", n_stb, 1);
      chk("t3_grant", {28'h0, o_grant}, 32'b0010);

      // Live value update while dwelling.
      do_reset();
      vals = '0;
      vals[15:0] = 16'h0005;
      req = 4'b0001;
      cyc(); cyc();
      chk("t4_num5", {16'h0, o_number_to_display}, 32'h0005);
      vals[15:0] = 16'h0006;
      cyc();
      chk("t4_num6", {16'h0, o_number_to_display}, 32'h0006);

      // Early release by source 3, source 1 waiting.
      do_reset();
      vals[63:48] = 16'hABCD;
      req = 4'b1000;
      cyc(); cyc(); cyc(); cyc();
      req = 4'b0010;
      vals[63:48] = 16'h1111;
      cyc();
      chk("t5_grant0", {28'h0, o_grant}, 32'h0);
      chk("t5_valid0", {31'h0, o_valid}, 32'h0);
      chk("t5_hold", {16'h0, o_number_to_display}, 32'hABCD);
      cyc();
      chk("t5_grant1", {28'h0, o_grant}, 32'b0010);
      chk("t5_idx1", {30'h0, o_active_idx}, 32'd1);

      // Reset mid-dwell; pointer restart favours source 3 when only it asks.
      do_reset();
      req = 4'b1111;
      cyc(); cyc(); cyc(); cyc();
      #2 rst_n = 1'b0;
      #1 model_reset();
      chk("t6_async_zero",
          {8'h0, o_grant, o_active_idx, o_number_to_display, o_valid, o_switch_stb},
          32'h0);
      req = 4'b1000;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(); cyc();
      chk("t6_grant3", {28'h0, o_grant}, 32'b1000);
      chk("t6_idx3", {30'h0, o_active_idx}, 32'd3);

`ifdef DISPLAY_SCHED_LOCK_EN
      do_reset();
      req = 4'b1111;
      cyc(); cyc();
      lock = 1'b1;
      for (int c = 0; c < 20; c++) cyc();
      chk("t7_locked", {28'h0, o_grant}, 32'b0001);
      lock = 1'b0;
      for (int c = 0; c < 7; c++) cyc();
      chk("t7_still", {28'h0, o_grant}, 32'b0001);
      cyc();
      chk("t7_gap", {31'h0, o_valid}, 32'd0);
      cyc();
      chk("t7_next", {28'h0, o_grant}, 32'b0010);
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         if ($urandom_range(0, 6) == 0) req = 4'($urandom);
         if ($urandom_range(0, 2) == 0)
            vals[16*$urandom_range(0, 3) +: 16] = 16'($urandom);
`ifdef DISPLAY_SCHED_LOCK_EN
         if ($urandom_range(0, 9) == 0) lock = ~lock;
`endif
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Time-slices the single numeric LED display between NUM_SOURCES requesters, each offering a 16-bit value.
- Round-robin arbitration with a fixed dwell period per grant.
- The selected value drives the number input of the numeric display controller.
- Sits between application counters/sensors and the display controller, replacing a hard-wired number source.

Parameters:
- NUM_SOURCES, 4: number of requesters, 2..8.
- SRC_IDX_WIDTH, 2: width of the source index; must be at least clog2(NUM_SOURCES).
- DWELL_CYCLES, 25_000_000: clock cycles per grant slot (1 s at 25 MHz); must be ≥2.
- DWELL_WIDTH, 25: dwell counter width; must be at least clog2(DWELL_CYCLES).

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_SOURCES  per-source display request, level, held while the source wants display time.
- i_values  in  16*NUM_SOURCES  packed values; source k occupies bits [16k+15:16k].
- o_grant  out  NUM_SOURCES  one-hot grant to the displayed source; all zero when idle.
- o_active_idx  out  SRC_IDX_WIDTH  index of the granted or last-granted source.
- o_number_to_display  out  16  value fed to the display controller.
- o_valid  out  1  high while a source is granted.
- o_switch_stb  out  1  single-cycle pulse when a new grant takes effect.

Behaviour:
- Reset is asynchronous and active-low. While i_reset_n is low:
  - o_grant=0, o_active_idx=0, o_number_to_display=0, o_valid=0, o_switch_stb=0.
  - state=IDLE, dwell counter=0.
  - Round-robin pointer = NUM_SOURCES-1, so the first search starts at source 0.
- States: IDLE, SELECT, DWELL. Illegal encodings return to IDLE.
- IDLE:
  - Outputs hold o_number_to_display and o_active_idx. o_valid=0, o_grant=0.
  - Any i_req bit set → SELECT next cycle.
- SELECT (exactly one cycle):
  - Combinational search for the first requesting source starting at pointer+1, wrapping modulo NUM_SOURCES.
  - On the clock edge leaving SELECT, all of the following register together:
    - o_grant=onehot(winner), o_active_idx=winner, pointer=winner.
    - o_valid=1, o_switch_stb=1.
    - o_number_to_display=i_values[winner].
    - dwell counter=DWELL_CYCLES-1.
    - Next state DWELL.
  - If i_req is all zero during SELECT → IDLE, outputs unchanged.
- DWELL:
  - o_number_to_display re-registers the granted source's value every cycle (1-cycle latency; live updates visible).
  - Counter decrements by 1 per cycle. o_switch_stb=0.
- Expiry (counter==0):
  - Any other source requesting → SELECT.
  - Else, granted source still requesting → reload DWELL_CYCLES-1 and stay in DWELL. Grant is unchanged and there is no strobe.
  - Else → IDLE.
- Early release: if the granted source's i_req drops in DWELL, leave DWELL next cycle, regardless of counter.
  - Go to SELECT if any other request is present, else IDLE.
  - Clear o_grant and o_valid on that same edge.
  - o_number_to_display keeps its last value.
- Simultaneous expiry and release: release rules apply; the result is identical.
- Worst-case gap between grants is 1 cycle (the SELECT cycle), during which o_valid=0.
- Fairness: with all sources requesting continuously, grants rotate 0,1,…,N-1,0. Each source holds the grant for exactly DWELL_CYCLES cycles, with one SELECT cycle between slots.
- Reset mid-operation: all registers return to reset values immediately; no strobe is emitted.

Optional Feature:
- Macro: DISPLAY_SCHED_LOCK_EN.
- When defined, the block adds port i_lock (in, 1).
  - While i_lock=1 in DWELL, the counter freezes and expiry is suppressed, so the current grant persists.
  - Early release on i_req drop still applies.
  - In IDLE, i_lock has no effect.
  - When i_lock is deasserted, counting resumes from the frozen value.
- When undefined, the port is absent and behaviour is exactly as above.

Test Plan (DWELL_CYCLES=8, NUM_SOURCES=4):
- Reset then i_req=4'b0100, i_values[2]=16'h1234 → 2 cycles later o_grant=4'b0100, o_active_idx=2, o_number_to_display=16'h1234, o_switch_stb pulses once.
- i_req=4'b1111 held → grant sequence 0,1,2,3,0. Each grant lasts 8 cycles with o_valid low for 1 cycle between grants; each grant change gives exactly one strobe.
- Only source 1 requesting for 30 cycles → grant stays 4'b0010 throughout, o_switch_stb pulses only once.
- Source 0 granted, i_values[0] steps 16'h0005→16'h0006 → o_number_to_display=16'h0006 one cycle later.
- Source 3 granted, i_req[3] drops at dwell count 5 → next cycle o_grant=0, o_valid=0, o_number_to_display holds. If i_req[1]=1, source 1 is granted one cycle after that.
- i_reset_n pulsed low asynchronously mid-DWELL → outputs zero immediately. After release with i_req=4'b1000, source 0 is not granted and source 3 wins.
- DISPLAY_SCHED_LOCK_EN defined: i_lock=1 with all sources requesting for 20 cycles → grant unchanged. After i_lock=0, the remaining dwell counts out, then the grant rotates.
